// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two master ports, the shared slave bus and the arbiter status outputs.
interface mem_arbiter_if;
    logic        i_m0_req, i_m0_we, o_m0_ack;
    logic [15:0] i_m0_addr;
    logic [7:0]  i_m0_dat, o_m0_dat;
    logic        i_m1_req, i_m1_we, o_m1_ack;
    logic [15:0] i_m1_addr;
    logic [7:0]  i_m1_dat, o_m1_dat;
    logic [15:0] o_s_addr;
    logic [7:0]  o_s_dat, i_s_dat;
    logic        o_s_we, o_s_stb, i_s_ack;
    logic [1:0]  o_grant;
    logic        o_err;
    modport master (
        input  i_m0_req, i_m0_addr, i_m0_we, i_m0_dat,
        input  i_m1_req, i_m1_addr, i_m1_we, i_m1_dat,
        input  i_s_dat, i_s_ack,
        output o_m0_dat, o_m0_ack, o_m1_dat, o_m1_ack,
        output o_s_addr, o_s_dat, o_s_we, o_s_stb, o_grant, o_err
    );
    modport slave (
        output i_m0_req, i_m0_addr, i_m0_we, i_m0_dat,
        output i_m1_req, i_m1_addr, i_m1_we, i_m1_dat,
        output i_s_dat, i_s_ack,
        input  o_m0_dat, o_m0_ack, o_m1_dat, o_m1_ack,
        input  o_s_addr, o_s_dat, o_s_we, o_s_stb, o_grant, o_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for an async-ack 8-bit slave bus with a wait-state watchdog.
module mem_arbiter #(
    parameter int         TIMEOUT  = 15,
    parameter logic [7:0] ERR_DATA = 8'hFF
) (
    input logic         i_clk,
    input logic         i_reset,
    mem_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, ACK} state_t;
    state_t        state, nxt;
    logic          last, owner, err_r, win, go, tmo;
    logic [CW-1:0] cnt;
    assign go  = bus.i_m0_req | bus.i_m1_req;
    // master 1 wins unless master 0 is alone or master 1 had the last grant
    assign win = ~(bus.i_m0_req & (~bus.i_m1_req | last));
    assign tmo = cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) state <= IDLE;
        else         state <= nxt;
    always_comb
        nxt = state == IDLE   ? (go ? ACTIVE : IDLE) :
              state == ACTIVE ? ((bus.i_s_ack | tmo) ? ACK : ACTIVE) : IDLE;
    always_comb begin
        bus.o_s_stb  = state == ACTIVE;
        bus.o_grant  = state == IDLE ? 2'b00 : {owner, ~owner};
        bus.o_m0_ack = state == ACK && !owner;
        bus.o_m1_ack = state == ACK && owner;
        bus.o_err    = state == ACK && err_r;
    end
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            bus.o_s_addr <= '0;
            bus.o_s_dat  <= '0;
            bus.o_s_we   <= 1'b0;
            bus.o_m0_dat <= '0;
            bus.o_m1_dat <= '0;
            last         <= 1'b1;
            owner        <= 1'b0;
            err_r        <= 1'b0;
            cnt          <= '0;
        end else if (state == IDLE && go) begin
            bus.o_s_addr <= win ? bus.i_m1_addr : bus.i_m0_addr;
            bus.o_s_dat  <= win ? bus.i_m1_dat : bus.i_m0_dat;
            bus.o_s_we   <= win ? bus.i_m1_we : bus.i_m0_we;
            owner        <= win;
            last         <= win;
            err_r        <= 1'b0;
            cnt          <= '0;
        end else if (state == ACTIVE) begin
            if (bus.i_s_ack | tmo) begin
                err_r <= ~bus.i_s_ack;
                if (!bus.o_s_we && owner)  bus.o_m1_dat <= bus.i_s_ack ? bus.i_s_dat : ERR_DATA;
                if (!bus.o_s_we && !owner) bus.o_m0_dat <= bus.i_s_ack ? bus.i_s_dat : ERR_DATA;
            end else
                cnt <= cnt + 1'b1;
        end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 8-bit asynchronous-ack memory/peripheral bus between two masters: master 0 is the CPU wrapper, master 1 is a DMA/video fetch engine.
- Master 0's ack feeds the CPU wrapper's i_ack, and master 0's request is derived from its i_active.
- The block does round-robin arbitration and per-transfer sequencing of the slave strobe/ack handshake.
- A wait-state watchdog terminates hung slave cycles.

Parameters:
- TIMEOUT, 15: cycles in ACTIVE without i_s_ack before a forced completion. Legal range 1..255.
- ERR_DATA, 8'hFF: read data returned to the master on timeout.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_m0_req  in  1  master 0 request; held high until o_m0_ack
- i_m0_addr  in  16  master 0 address
- i_m0_we  in  1  master 0 write enable
- i_m0_dat  in  8  master 0 write data
- o_m0_dat  out  8  master 0 read data; valid while o_m0_ack is high
- o_m0_ack  out  1  master 0 one-cycle completion pulse
- i_m1_req, i_m1_addr, i_m1_we, i_m1_dat, o_m1_dat, o_m1_ack: same as master 0, for master 1
- o_s_addr  out  16  slave address (registered)
- o_s_dat  out  8  slave write data (registered)
- o_s_we  out  1  slave write enable (registered)
- o_s_stb  out  1  slave cycle strobe
- i_s_dat  in  8  slave read data, sampled when i_s_ack is high
- i_s_ack  in  1  slave completion
- o_grant  out  2  one-hot owner of the current cycle; 00 when idle
- o_err  out  1  one-cycle pulse on a timeout completion

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, asynchronous and active-high.
- Reset values:
  - state = IDLE, last_grant = master 1 (so master 0 wins the first tie).
  - All outputs 0, including o_s_addr, o_s_dat and o_mX_dat.
  - Wait counter = 0.
- Reset asserted mid-transfer: the transfer is abandoned immediately and no ack is issued.
- The FSM has three states: IDLE, ACTIVE, ACK.
- IDLE:
  - No request pending: stay in IDLE.
  - Only one request: grant that master.
  - Both requesting: grant the master that is not last_grant (round-robin).
  - On grant:
    - Register the winner's addr/we/dat into o_s_addr/o_s_we/o_s_dat.
    - Set o_grant and o_s_stb = 1, clear the wait counter, update last_grant.
    - Go to ACTIVE.
  - Request inputs are sampled only in IDLE.
- ACTIVE:
  - o_s_stb = 1. Slave address/data/we stay stable for the whole cycle.
  - If i_s_ack = 1:
    - If o_s_we = 0, capture i_s_dat into the owner's o_mX_dat.
    - Drop o_s_stb and go to ACK.
  - Else, if the wait counter = TIMEOUT-1:
    - Load ERR_DATA into the owner's o_mX_dat (reads only).
    - Set o_err = 1 for the next cycle, drop o_s_stb and go to ACK.
  - Otherwise, increment the wait counter.
  - i_s_ack and the timeout in the same cycle: i_s_ack wins and o_err stays 0.
- ACK:
  - The owner's o_mX_ack = 1 for exactly one cycle. o_err is high here only if a timeout occurred.
  - o_grant is cleared on the transition back to IDLE.
  - The owner's request is ignored in this cycle (it belongs to the completed transfer).
  - Go to IDLE.
- Latency and throughput:
  - Zero-wait slave (ack in the first ACTIVE cycle): request seen in IDLE at cycle 0, o_s_stb high at cycle 1, o_mX_ack at cycle 2.
  - Minimum transfer period is 3 cycles.
  - Each extra wait cycle adds 1.
- Masters must hold addr/we/dat stable while req is high. Dropping req after grant does not abort the transfer: it completes and the ack is still pulsed.
- i_s_ack outside ACTIVE is ignored.
- o_mX_dat holds its last value between acks. A write does not modify o_mX_dat.
- The wait counter width is ceil(log2(TIMEOUT+1)) and it never wraps, because the transfer terminates at TIMEOUT-1.

Test Plan:
- Reset, then m0 reads 16'h1234 with the slave acking immediately and i_s_dat = 8'hA5:
  - o_s_stb is high in cycle 1 only.
  - o_m0_ack pulses in cycle 2 with o_m0_dat = 8'hA5.
  - o_grant goes 01 then 00.
- m0 and m1 both hold req continuously for 4 transfers:
  - Grants are m0, m1, m0, m1.
  - Each o_mX_ack fires once per transfer.
  - No cycle has both acks high.
- m1 writes 8'h3C to 16'hC000 with 3 wait states:
  - o_s_addr = C000, o_s_we = 1 and o_s_dat = 3C, all stable for 4 ACTIVE cycles.
  - o_m1_ack fires 1 cycle after i_s_ack.
  - o_m1_dat is unchanged.
- Slave never acks, m0 reads with TIMEOUT = 15:
  - o_s_stb is high for exactly 15 cycles.
  - o_m0_ack and o_err pulse together, with o_m0_dat = 8'hFF.
- i_s_ack arrives in the same cycle the counter reaches TIMEOUT-1: normal completion with captured data, and o_err = 0.
- i_reset asserted in the second ACTIVE cycle:
  - All outputs drop to 0 asynchronously.
  - No ack is issued.
  - After release, the first tie is granted to m0.
